crypt_uart_ctrl: RTL and testbench
==================================

CRYPT_UART_CTRL -- requirements
Module: crypt_uart_ctrl

Interface
REQ-001 Parameter BLK_BYTES, default 8: cipher block size in bytes (1..16).
REQ-002 Parameter KEY_BYTES, default 8: key size in bytes (1..32).
REQ-003 Parameter KEY_SLOTS, default 4: number of stored keys (1..4).
REQ-004 Parameter TIMEOUT_CYC, default 5000000: maximum idle clocks between received bytes of one frame; 0 disables the timeout.
REQ-005 Port i_Clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Port i_Rst  in  1  reset, asynchronous, active-low.
REQ-007 Port i_RxValid  in  1  one-cycle strobe, received UART byte present.
REQ-008 Port i_RxData  in  8  received byte, valid with i_RxValid.
REQ-009 Port o_TxValid  out  1  byte offered to the UART transmitter.
REQ-010 Port o_TxData  out  8  byte to transmit.
REQ-011 Port i_TxReady  in  1  transmitter accepts; a byte is consumed in any cycle with o_TxValid and i_TxReady both high.
REQ-012 Port o_CipStart  out  1  one-cycle cipher start pulse.
REQ-013 Port o_CipDecrypt  out  1  1 = decrypt, 0 = encrypt; held stable from start to done.
REQ-014 Port o_CipKey  out  KEY_BYTES*8  selected slot key.
REQ-015 Port o_CipData  out  BLK_BYTES*8  block to the cipher.
REQ-016 Port i_CipDone  in  1  one-cycle strobe, result valid.
REQ-017 Port i_CipData  in  BLK_BYTES*8  cipher result, sampled on i_CipDone.
REQ-018 Port o_Busy  out  1  high whenever state is not IDLE.
REQ-019 Port o_Err  out  1  sticky; set by any error status, cleared by reset or by the next OK status.

Function
REQ-020 Command byte: bits[1:0] op (00 load key, 01 encrypt, 10 decrypt, 11 status query); bits[3:2] slot index; bits[7:4] ignored.
REQ-021 States: IDLE, RX_KEY, RX_DATA, START, WAIT, TX_STAT, TX_DATA.
REQ-022 IDLE: on i_RxValid, latch the command. Route op 00 to RX_KEY, op 01/10 to RX_DATA, and op 11 to TX_STAT.
REQ-023 Slot index >= KEY_SLOTS: go to TX_STAT with status 0xE1 and discard following payload bytes. Op 11 is not checked.
REQ-024 Op 01/10 targeting a slot whose valid bit is 0: go to TX_STAT with status 0xE3.
REQ-025 RX_KEY/RX_DATA: shift each byte in MSB-first, so the first byte lands in the top byte. After KEY_BYTES or BLK_BYTES bytes, exit in the same cycle as the last strobe.
REQ-026 Key frame complete: write the slot and set its valid bit, then go to TX_STAT with status 0x00.
REQ-027 Data frame complete: go to START. START asserts o_CipStart for exactly one cycle, then WAIT.
REQ-028 WAIT: on i_CipDone, capture i_CipData into the data register and go to TX_STAT with status 0x00. There is no timeout in WAIT.
REQ-029 Inter-byte counter: counts in RX_KEY/RX_DATA, cleared on each i_RxValid. At TIMEOUT_CYC, discard the partial frame (the slot is not written) and go to TX_STAT with status 0xE2.
REQ-030 TX_STAT: o_TxValid=1 with the status byte. Op 11 status byte = {4'h0, slot valid bits}, zero-padded above KEY_SLOTS.
REQ-031 On acceptance: if status is 0x00 and op is 01/10, go to TX_DATA; otherwise go to IDLE.
REQ-032 TX_DATA: send the data register MSB byte first, BLK_BYTES bytes, one per acceptance, then go to IDLE.
REQ-033 o_TxData and o_TxValid hold stable while i_TxReady is low.
REQ-034 i_RxValid in START, WAIT, TX_STAT or TX_DATA is ignored and the byte is dropped.
REQ-035 i_CipDone outside WAIT is ignored.
REQ-036 A key-slot write and a read of the same slot never coincide; o_CipKey reflects the slot latched by the command.

Reset
REQ-037 Reset forces state IDLE; all slot keys, valid bits, data register, byte counter and timeout counter are 0.
REQ-038 Reset forces o_TxValid=0, o_CipStart=0, o_CipDecrypt=0, o_Busy=0, o_Err=0, o_TxData=0.
REQ-039 Reset asserted mid-frame or mid-cipher abandons the operation; no output pulse is emitted after release until a new command arrives.

Verification
REQ-040 Key load: cmd 0x04 then bytes 01..08 -> slot 1 = 0x0102030405060708, valid bits = 0010, TX 0x00, o_Err=0.
REQ-041 Encrypt: after REQ-040, cmd 0x05 plus 8 bytes -> exactly one o_CipStart, o_CipDecrypt=0. Model returns 0xA1..A8 -> TX 0x00, A1, A2, ... A8 in order, with i_TxReady toggled randomly.
REQ-042 Unloaded slot: cmd 0x0A with slot 2 empty -> TX 0xE3 only, no o_CipStart, o_Err=1. Then cmd 0x03 -> TX 0x02, o_Err=0.
REQ-043 Bad slot: KEY_SLOTS=2, cmd 0x0C -> TX 0xE1, state returns to IDLE, key store unchanged.
REQ-044 Timeout: TIMEOUT_CYC=100, cmd 0x00, 3 bytes, then silence -> TX 0xE2 at 100 cycles after the 3rd byte, slot 0 valid bit stays 0.
REQ-045 Reset in WAIT: assert i_Rst low for 2 cycles, then pulse i_CipDone -> no TX byte, o_Busy=0, all valid bits 0.

Source files
------------

// File: rtl/crypt_uart_ctrl.sv
// crypt_uart_ctrl: byte-oriented UART command front-end for a block cipher.
// Handles key slot loading, encrypt/decrypt requests and status reporting.
module crypt_uart_ctrl #(
    parameter int unsigned BLK_BYTES   = 8,
    parameter int unsigned KEY_BYTES   = 8,
    parameter int unsigned KEY_SLOTS   = 4,
    parameter int unsigned TIMEOUT_CYC = 5000000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_RxValid,
    input  logic [7:0]             i_RxData,
    output logic                   o_TxValid,
    output logic [7:0]             o_TxData,
    input  logic                   i_TxReady,
    output logic                   o_CipStart,
    output logic                   o_CipDecrypt,
    output logic [KEY_BYTES*8-1:0] o_CipKey,
    output logic [BLK_BYTES*8-1:0] o_CipData,
    input  logic                   i_CipDone,
    input  logic [BLK_BYTES*8-1:0] i_CipData,
    output logic                   o_Busy,
    output logic                   o_Err
);
    localparam int unsigned KW    = KEY_BYTES * 8;
    localparam int unsigned BW    = BLK_BYTES * 8;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ENC   = 2'b01;
    localparam logic [1:0] OP_DEC   = 2'b10;
    localparam logic [1:0] OP_QUERY = 2'b11;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_SLOT = 8'hE1;
    localparam logic [7:0] ST_TIMEOUT  = 8'hE2;
    localparam logic [7:0] ST_NO_KEY   = 8'hE3;

    typedef enum logic [2:0] {
        S_IDLE, S_RX_KEY, S_RX_DATA, S_START, S_WAIT, S_TX_STAT, S_TX_DATA
    } state_t;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [1:0]       r_slot;
    logic [KW-1:0]    r_keys [0:3];
    logic [3:0]       r_valid;
    logic [KW-1:0]    r_key_sh;
    logic [BW-1:0]    r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_to;
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;
    logic             r_cip_start;
    logic             r_cip_dec;
    logic [KW-1:0]    r_cip_key;
    logic             r_busy;
    logic             r_err;

    logic [1:0]    w_cmd_op;
    logic [1:0]    w_cmd_slot;
    logic          w_cmd_bad_slot;
    logic          w_last_key;
    logic          w_last_blk;
    logic          w_timeout;
    logic          w_tx_acc;
    logic [KW-1:0] w_key_in;
    logic [BW-1:0] w_data_in;
    logic [BW-1:0] w_data_sh;
    logic          w_stat_go;
    logic [7:0]    w_stat_byte;
    logic          w_stat_err;

    assign w_cmd_op       = i_RxData[1:0];
    assign w_cmd_slot     = i_RxData[3:2];
    assign w_cmd_bad_slot = 32'(w_cmd_slot) >= KEY_SLOTS;
    assign w_last_key     = r_cnt == CNT_W'(KEY_BYTES - 1);
    assign w_last_blk     = r_cnt == CNT_W'(BLK_BYTES - 1);
    assign w_timeout      = (TIMEOUT_CYC != 0) && (r_to == TO_W'(TIMEOUT_CYC - 1));
    assign w_tx_acc       = r_tx_valid & i_TxReady;
    // MSB-first shift: the first received byte ends up in the top byte
    assign w_key_in       = KW'({r_key_sh, i_RxData});
    assign w_data_in      = BW'({r_data, i_RxData});
    assign w_data_sh      = BW'({r_data, 8'h00});

    // Decide when the FSM enters TX_STAT and with which status byte
    always_comb begin
        w_stat_go   = 1'b0;
        w_stat_byte = ST_OK;
        w_stat_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_RxValid) begin
                    if (w_cmd_op == OP_QUERY) begin
                        w_stat_go   = 1'b1;
                        w_stat_byte = {4'h0, r_valid};
                    end else if (w_cmd_bad_slot) begin
                        w_stat_go   = 1'b1;
                        w_stat_byte = ST_BAD_SLOT;
                        w_stat_err  = 1'b1;
                    end else if (w_cmd_op != OP_LOAD && !r_valid[w_cmd_slot]) begin
                        w_stat_go   = 1'b1;
                        w_stat_byte = ST_NO_KEY;
                        w_stat_err  = 1'b1;
                    end
                end
            end
            S_RX_KEY: begin
                if (i_RxValid) begin
                    w_stat_go = w_last_key;
                end else if (w_timeout) begin
                    w_stat_go   = 1'b1;
                    w_stat_byte = ST_TIMEOUT;
                    w_stat_err  = 1'b1;
                end
            end
            S_RX_DATA: begin
                if (!i_RxValid && w_timeout) begin
                    w_stat_go   = 1'b1;
                    w_stat_byte = ST_TIMEOUT;
                    w_stat_err  = 1'b1;
                end
            end
            S_WAIT: begin
                w_stat_go = i_CipDone;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_slot      <= 2'b00;
            for (int i = 0; i < 4; i++) r_keys[i] <= '0;
            r_valid     <= 4'h0;
            r_key_sh    <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_to        <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_cip_start <= 1'b0;
            r_cip_dec   <= 1'b0;
            r_cip_key   <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cip_start <= 1'b0;
            if (w_stat_go) begin
                r_state    <= S_TX_STAT;
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_stat_byte;
                r_err      <= w_stat_err;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_RxValid) begin
                        r_op      <= w_cmd_op;
                        r_slot    <= w_cmd_slot;
                        r_cip_dec <= (w_cmd_op == OP_DEC);
                        r_cip_key <= r_keys[w_cmd_slot];
                        r_cnt     <= '0;
                        r_to      <= '0;
                        r_busy    <= 1'b1;
                        if (!w_stat_go)
                            r_state <= (w_cmd_op == OP_LOAD) ? S_RX_KEY : S_RX_DATA;
                    end
                end
                S_RX_KEY: begin
                    if (i_RxValid) begin
                        r_key_sh <= w_key_in;
                        r_to     <= '0;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        if (w_last_key) begin
                            r_keys[r_slot]  <= w_key_in;
                            r_valid[r_slot] <= 1'b1;
                        end
                    end else begin
                        r_to <= r_to + TO_W'(1);
                    end
                end
                S_RX_DATA: begin
                    if (i_RxValid) begin
                        r_data <= w_data_in;
                        r_to   <= '0;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (w_last_blk) begin
                            r_state     <= S_START;
                            r_cip_start <= 1'b1;
                        end
                    end else begin
                        r_to <= r_to + TO_W'(1);
                    end
                end
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    if (i_CipDone) r_data <= i_CipData;
                end
                S_TX_STAT: begin
                    if (w_tx_acc) begin
                        if (r_tx_data == ST_OK && (r_op == OP_ENC || r_op == OP_DEC)) begin
                            r_state   <= S_TX_DATA;
                            r_tx_data <= r_data[BW-1 -: 8];
                            r_cnt     <= '0;
                        end else begin
                            r_state    <= S_IDLE;
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                S_TX_DATA: begin
                    if (w_tx_acc) begin
                        if (w_last_blk) begin
                            r_state    <= S_IDLE;
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_cnt     <= r_cnt + CNT_W'(1);
                            r_data    <= w_data_sh;
                            r_tx_data <= w_data_sh[BW-1 -: 8];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_TxValid    = r_tx_valid;
    assign o_TxData     = r_tx_data;
    assign o_CipStart   = r_cip_start;
    assign o_CipDecrypt = r_cip_dec;
    assign o_CipKey     = r_cip_key;
    assign o_CipData    = r_data;
    assign o_Busy       = r_busy;
    assign o_Err        = r_err;

endmodule

// File: tb/tb_crypt_uart_ctrl.sv
// tb_crypt_uart_ctrl: directed bench for crypt_uart_ctrl with hand-computed expectations.
// Three slots so one instance covers both the empty-slot and out-of-range-slot cases.
module tb_crypt_uart_ctrl;
    localparam int unsigned BLK_BYTES   = 8;
    localparam int unsigned KEY_BYTES   = 8;
    localparam int unsigned KEY_SLOTS   = 3;
    localparam int unsigned TIMEOUT_CYC = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        cip_start;
    logic        cip_dec;
    logic [63:0] cip_key;
    logic [63:0] cip_data_o;
    logic        cip_done = 1'b0;
    logic [63:0] cip_data_i = 64'd0;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_start  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (cip_start) n_start <= n_start + 1;

    crypt_uart_ctrl #(
        .BLK_BYTES(BLK_BYTES), .KEY_BYTES(KEY_BYTES),
        .KEY_SLOTS(KEY_SLOTS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_dut (
        .i_Clk(clk), .i_Rst(rst_n),
        .i_RxValid(rx_valid), .i_RxData(rx_data),
        .o_TxValid(tx_valid), .o_TxData(tx_data), .i_TxReady(tx_ready),
        .o_CipStart(cip_start), .o_CipDecrypt(cip_dec), .o_CipKey(cip_key),
        .o_CipData(cip_data_o), .i_CipDone(cip_done), .i_CipData(cip_data_i),
        .o_Busy(busy), .o_Err(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Accept one TX byte; rnd stalls i_TxReady randomly to exercise hold behaviour
    task automatic expect_tx(input string tag, input logic [7:0] exp, input bit rnd);
        logic [7:0] first = 8'h00;
        logic [7:0] got   = 8'h00;
        bit seen = 1'b0;
        bit ok   = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (tx_valid) begin
                if (!seen) begin
                    first = tx_data;
                    seen  = 1'b1;
                end
                tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (tx_ready) begin
                    got = tx_data;
                    ok  = 1'b1;
                    @(posedge clk);
                    #1 tx_ready = 1'b0;
                end
            end
        end
        check(tag, {55'd0, ok, got}, {55'd0, 1'b1, exp});
        if (rnd) check({tag, "_hold"}, {56'd0, first}, {56'd0, exp});
    endtask

    task automatic wait_start(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (cip_start) seen = 1'b1;
            else @(negedge clk);
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic cip_finish(input logic [63:0] res);
        repeat (3) @(negedge clk);
        cip_data_i = res;
        cip_done   = 1'b1;
        @(negedge clk);
        cip_done   = 1'b0;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int hits = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx_valid || busy) hits++;
        end
        check(tag, 64'(hits), 64'd0);
    endtask

    initial begin
        int s0;
        int k;
        logic [63:0] dres;
        dres = 64'h0F1E2D3C4B5A6978;

        repeat (3) @(negedge clk);
        check("rst_txvalid", 64'(tx_valid), 64'd0);
        check("rst_txdata",  64'(tx_data),  64'd0);
        check("rst_start",   64'(cip_start), 64'd0);
        check("rst_decrypt", 64'(cip_dec),  64'd0);
        check("rst_busy",    64'(busy),     64'd0);
        check("rst_err",     64'(err),      64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Key load into slot 1
        send_byte(8'h04);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        expect_tx("load_stat", 8'h00, 1'b0);
        check("load_err", 64'(err), 64'd0);
        send_byte(8'h03);
        expect_tx("load_query", 8'h02, 1'b0);

        // Encrypt with slot 1, random transmitter back-pressure
        s0 = n_start;
        send_byte(8'h05);
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
        wait_start("enc_start");
        check("enc_decrypt", 64'(cip_dec), 64'd0);
        check("enc_key",  cip_key,    64'h0102030405060708);
        check("enc_data", cip_data_o, 64'h1112131415161718);
        cip_finish(64'hA1A2A3A4A5A6A7A8);
        check("enc_nstart", 64'(n_start - s0), 64'd1);
        expect_tx("enc_stat", 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) expect_tx("enc_byte", 8'hA1 + 8'(i), 1'b1);
        expect_quiet("enc_idle", 5);

        // Decrypt with slot 1
        send_byte(8'h06);
        for (int i = 0; i < 8; i++) send_byte(8'h21 + 8'(i));
        wait_start("dec_start");
        check("dec_decrypt", 64'(cip_dec), 64'd1);
        check("dec_data", cip_data_o, 64'h2122232425262728);
        cip_finish(dres);
        expect_tx("dec_stat", 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) expect_tx("dec_byte", dres[(7-i)*8 +: 8], 1'b0);

        // Decrypt from an empty slot
        s0 = n_start;
        send_byte(8'h0A);
        expect_tx("noslot_stat", 8'hE3, 1'b0);
        check("noslot_err", 64'(err), 64'd1);
        expect_quiet("noslot_quiet", 10);
        check("noslot_nstart", 64'(n_start - s0), 64'd0);
        send_byte(8'h03);
        expect_tx("noslot_query", 8'h02, 1'b0);
        check("noslot_err_clr", 64'(err), 64'd0);

        // Out-of-range slot; the following byte arrives during TX_STAT and must be dropped
        send_byte(8'h0C);
        send_byte(8'h77);
        expect_tx("badslot_stat", 8'hE1, 1'b0);
        check("badslot_err", 64'(err), 64'd1);
        expect_quiet("badslot_quiet", 10);
        send_byte(8'h03);
        expect_tx("badslot_query", 8'h02, 1'b0);

        // Partial key frame then silence
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        k = 0;
        while (!tx_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("to_latency", 64'(k), 64'd100);
        expect_tx("to_stat", 8'hE2, 1'b0);
        check("to_err", 64'(err), 64'd1);
        send_byte(8'h03);
        expect_tx("to_query", 8'h02, 1'b0);

        // Reset while waiting on the cipher
        send_byte(8'h05);
        for (int i = 0; i < 8; i++) send_byte(8'h31 + 8'(i));
        wait_start("rw_start");
        repeat (2) @(negedge clk);
        check("rw_busy_wait", 64'(busy), 64'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = n_start;
        cip_finish(64'h5555AAAA5555AAAA);
        expect_quiet("rw_quiet", 20);
        check("rw_nstart", 64'(n_start - s0), 64'd0);
        check("rw_err", 64'(err), 64'd0);
        send_byte(8'h03);
        expect_tx("rw_query", 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
        $fatal(1);
    end

endmodule
